alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_if.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, ALU-stage and result signals of alu_issue_ctrl
interface alu_issue_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_op;
    logic       res_zero;
    logic       busy;
    logic [7:0] op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op,
               res_zero, busy, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op,
               res_zero, busy, op_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO feeding an external 4-bit ALU with a held result stage
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [10:0]       mem_q [FIFO_DEPTH];
    logic [10:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        alu_a_q, alu_a_d;
    logic [3:0]        alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              res_valid_q, res_valid_d;
    logic [3:0]        res_data_q, res_data_d;
    logic [2:0]        res_op_q, res_op_d;
    logic [7:0]        op_count_q, op_count_d;

    logic fifo_empty;
    logic cmd_ready;
    logic push;
    logic pop;
    logic capture;
    logic complete;
    logic res_hs;

    // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = (count_q < DEPTH_C);
    assign push       = bus.cmd_valid && cmd_ready;
    assign res_hs     = res_valid_q && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = ISSUE;
            ISSUE:   state_d = HOLD;
            HOLD:    if (res_hs) state_d = fifo_empty ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE:  pop = !fifo_empty;
            ISSUE: capture = 1'b1;
            HOLD: begin
                complete = res_hs;
                pop      = res_hs && !fifo_empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        op_count_d  = op_count_q;
        if (pop) begin
            {alu_op_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
        end
        if (capture) begin
            res_data_d  = bus.alu_result;
            res_op_d    = alu_op_q;
            res_valid_d = 1'b1;
        end
        if (complete) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + 8'd1;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            op_count_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_zero  = (res_data_q == 4'd0);
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.op_count  = op_count_q;
endmodule
